uart_frame_accumulator: RTL

//  Parametrised byte-stream framer between a UART RX byte source and the command decoder.

---
 rtl/uart_accum_pkg.sv | 25 ++
 rtl/uart_frame_accumulator_if.sv | 31 +++
 rtl/accum_timeout_timer.sv | 44 ++++
 rtl/uart_frame_accumulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_accum_pkg
// Description : Shared constants for the UART frame accumulator: FSM state
//               encoding, error codes and default terminator bytes.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_accum_pkg;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_accum = 2'd1;
  localparam logic [1:0] c_st_term2 = 2'd2;
  localparam logic [1:0] c_st_hold  = 2'd3;

  localparam logic [1:0] c_err_none     = 2'd0;
  localparam logic [1:0] c_err_overflow = 2'd1;
  localparam logic [1:0] c_err_term     = 2'd2;
  localparam logic [1:0] c_err_checksum = 2'd3;

  localparam logic [7:0] c_term_cr = 8'h0D;
  localparam logic [7:0] c_term_hi = 8'hBE;
  localparam logic [7:0] c_term_lo = 8'hEF;

endpackage
`default_nettype wire

// File: rtl/uart_frame_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_accumulator_if
// Description : Byte-in / frame-out handshake bundle of the frame accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_frame_accumulator_if #(
  parameter int MAX_BYTES = 128,
  parameter int LEN_W     = 8
) ();

  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [MAX_BYTES*8-1:0] frame_data;
  logic [LEN_W-1:0]       frame_len;
  logic                   frame_valid;
  logic                   frame_ack;

  modport master (
    output in_data, in_valid, frame_ack,
    input  in_ready, frame_data, frame_len, frame_valid
  );

  modport slave (
    input  in_data, in_valid, frame_ack,
    output in_ready, frame_data, frame_len, frame_valid
  );

endinterface
`default_nettype wire

// File: rtl/accum_timeout_timer.sv
`default_nettype none
// ============================================================================
// Module      : accum_timeout_timer
// Description : Inter-byte idle counter; expired is high in the cycle the
//               TIMEOUT-th consecutive idle running cycle is reached.
// Revision    : 1.0 - initial release
// ============================================================================
module accum_timeout_timer #(
  parameter int TIMEOUT = 2000
) (
  input  wire  clk,
  input  wire  reset_n,
  input  wire  clear,
  input  wire  run,
  output logic expired
);

  localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(TIMEOUT - 1);
  localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

  logic [c_cnt_w-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (clear || !run) begin
      count_d = '0;
    end else if (count_q != c_last) begin
      count_d = count_q + c_one;
    end
  end

  assign expired = run && !clear && (count_q == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_frame_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : uart_frame_accumulator
// Description : Collects UART bytes into a frame until the CR (mode 0) or
//               BE EF (mode 1) terminator, flags overflow/terminator/timeout.
//               Optional feature macro: ACCUM_CHECKSUM_EN (trailing XOR byte).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_accumulator
  import uart_accum_pkg::*;
#(
  parameter int         MAX_BYTES = 128,
  parameter int         LEN_W     = 8,
  parameter int         TIMEOUT   = 2000,
  parameter logic [7:0] TERM_CR   = c_term_cr,
  parameter logic [7:0] TERM_HI   = c_term_hi,
  parameter logic [7:0] TERM_LO   = c_term_lo
) (
  input  wire                       clk,
  input  wire                       reset_n,
  input  wire                       mode,
  input  wire                       soft_clear,
  uart_frame_accumulator_if.slave   acc_if,
  output logic                      busy,
  output logic                      error,
  output logic [1:0]                error_code
);

  localparam int               c_idx_w   = $clog2(MAX_BYTES * 8);
  localparam logic [LEN_W-1:0] c_len_one = LEN_W'(1);
  localparam logic [LEN_W-1:0] c_len_max = LEN_W'(MAX_BYTES);

  logic [1:0]             state_q, state_d;
  logic [MAX_BYTES*8-1:0] buf_q, buf_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   mode_q, mode_d;
  logic                   error_q, error_d;
  logic [1:0]             code_q, code_d;

  logic               w_accept, w_run, w_expired, w_term_start;
  logic               w_store, w_done, w_err_fire;
  logic [1:0]         w_err_kind;
  logic [c_idx_w-1:0] w_wr_idx;

  assign w_accept = acc_if.in_valid && (state_q != c_st_hold);
  assign w_run    = (state_q == c_st_accum) || (state_q == c_st_term2);
  assign w_wr_idx = c_idx_w'({len_q, 3'b000});
  // Mode is taken live only for the opening byte; afterwards the latched copy rules.
  assign w_term_start = ((state_q == c_st_idle) ? mode : mode_q)
                      ? (acc_if.in_data == TERM_HI) : (acc_if.in_data == TERM_CR);

  accum_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (w_accept),
    .run     (w_run),
    .expired (w_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_st_idle;
      buf_q   <= '0;
      len_q   <= '0;
      mode_q  <= 1'b0;
      error_q <= 1'b0;
      code_q  <= c_err_none;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      len_q   <= len_d;
      mode_q  <= mode_d;
      error_q <= error_d;
      code_q  <= code_d;
    end
  end

`ifdef ACCUM_CHECKSUM_EN
  logic [7:0]         xor_q, xor_d;
  logic [LEN_W-1:0]   w_last_len;
  logic [c_idx_w-1:0] w_cs_idx;

  assign w_last_len = len_q - c_len_one;
  assign w_cs_idx   = c_idx_w'({w_last_len, 3'b000});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      xor_q <= 8'h00;
    end else begin
      xor_q <= xor_d;
    end
  end

  // Running XOR of every stored byte: zero means the last byte matches the rest.
  always_comb begin
    xor_d = xor_q;
    if (w_store) begin
      xor_d = xor_q ^ acc_if.in_data;
    end
    if ((state_d != c_st_accum) && (state_d != c_st_term2)) begin
      xor_d = 8'h00;
    end
  end
`endif

  always_comb begin : p_next_state
    state_d    = state_q;
    buf_d      = buf_q;
    len_d      = len_q;
    mode_d     = mode_q;
    error_d    = 1'b0;
    code_d     = code_q;
    w_store    = 1'b0;
    w_done     = 1'b0;
    w_err_fire = 1'b0;
    w_err_kind = c_err_none;

    case (state_q)
      c_st_idle: begin
        if (w_accept) begin
          code_d = c_err_none;
          mode_d = mode;
          if (!w_term_start) begin
            w_store = 1'b1;
            state_d = c_st_accum;
          end
        end
      end
      c_st_accum: begin
        if (w_accept) begin
          if (w_term_start) begin
            if (mode_q) begin
              state_d = c_st_term2;
            end else begin
              w_done = 1'b1;
            end
          end else if (len_q == c_len_max) begin
            w_err_fire = 1'b1;
            w_err_kind = c_err_overflow;
          end else begin
            w_store = 1'b1;
          end
        end else if (w_expired) begin
          w_err_fire = 1'b1;
          w_err_kind = c_err_term;
        end
      end
      c_st_term2: begin
        if (w_accept) begin
          if (acc_if.in_data == TERM_LO) begin
            w_done = 1'b1;
          end else begin
            w_err_fire = 1'b1;
            w_err_kind = c_err_term;
          end
        end else if (w_expired) begin
          w_err_fire = 1'b1;
          w_err_kind = c_err_term;
        end
      end
      c_st_hold: begin
        if (acc_if.frame_ack) begin
          state_d = c_st_idle;
          buf_d   = '0;
          len_d   = '0;
        end
      end
      default: state_d = c_st_idle;
    endcase

    if (w_store) begin
      buf_d[w_wr_idx +: 8] = acc_if.in_data;
      len_d                = len_q + c_len_one;
    end

    if (w_done) begin
`ifdef ACCUM_CHECKSUM_EN
      if ((len_q >= LEN_W'(2)) && (xor_q == 8'h00)) begin
        len_d                = w_last_len;
        buf_d[w_cs_idx +: 8] = 8'h00;
        state_d              = c_st_hold;
      end else begin
        w_err_fire = 1'b1;
        w_err_kind = c_err_checksum;
      end
`else
      state_d = c_st_hold;
`endif
    end

    if (w_err_fire) begin
      error_d = 1'b1;
      code_d  = w_err_kind;
      state_d = c_st_idle;
      buf_d   = '0;
      len_d   = '0;
    end

    // Abort overrides everything decided above, including the error report.
    if (soft_clear) begin
      state_d = c_st_idle;
      buf_d   = '0;
      len_d   = '0;
      error_d = 1'b0;
      code_d  = code_q;
    end
  end

  always_comb begin : p_outputs
    acc_if.in_ready    = (state_q != c_st_hold);
    acc_if.frame_valid = (state_q == c_st_hold);
    busy               = (state_q != c_st_idle);
  end

  assign acc_if.frame_data = buf_q;
  assign acc_if.frame_len  = len_q;
  assign error             = error_q;
  assign error_code        = code_q;

endmodule
`default_nettype wire
